// File: rtl/hilo_mult_unit.sv
// Sequential unsigned multiply / multiply-accumulate unit owning the HI/LO pair.
// Radix-2 shift-add over WIDTH cycles, then a single write-back cycle into HI/LO.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for an accepted start; HI/LO readable without stall
//   S_MUL  | one shift-add iteration per cycle, counter 0..WIDTH-1
//   S_WB   | product ready; HI/LO written (or accumulated) leaving this state
module hilo_mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic             hilo_rd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_WB   = 2'b10
    } state_t;

    localparam logic [1:0]       OP_MULTU = 2'b01;
    localparam logic [1:0]       OP_MADDU = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 start_ok;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   wb_sum;

    assign start_ok = start_i && ((op_i == OP_MULTU) || (op_i == OP_MADDU));

    // Product register holds {partial sum, remaining multiplier bits}; the
    // multiplier is consumed from bit 0 as the partial sum shifts in from the top.
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // Carry out of the 2*WIDTH-bit accumulate is dropped by the sum width.
    assign wb_sum = ((op_q == OP_MADDU) ? {hi_q, lo_q} : {(2*WIDTH){1'b0}}) + prod_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    op_d    = op_i;
                    mcand_d = rs_val_i;
                    prod_d  = {{WIDTH{1'b0}}, rt_val_i};
                end
            end
            S_MUL: begin
                prod_d = {step_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                hi_d    = wb_sum[2*WIDTH-1:WIDTH];
                lo_d    = wb_sum[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign stall_o = hilo_rd_i & busy_o;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: table of MULTU/MADDU vectors run back to
// back, plus hand-written stall/ignore, no-op and asynchronous reset sequences.
module tb_hilo_mult_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] rs = '0;
    logic [WIDTH-1:0] rt = '0;
    logic             hilo_rd = 1'b0;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] prev_hi = '0;
    logic [WIDTH-1:0] prev_lo = '0;

    hilo_mult_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .op_i      (op),
        .rs_val_i  (rs),
        .rt_val_i  (rt),
        .hilo_rd_i (hilo_rd),
        .hi_o      (hi),
        .lo_o      (lo),
        .busy_o    (busy),
        .done_o    (done),
        .stall_o   (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rt;
        logic [WIDTH-1:0] exp_hi;
        logic [WIDTH-1:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from the current sample point and follows it to its done cycle.
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
        int k;
        start = 1'b1; op = o; rs = a; rt = b;
        tick();
        start = 1'b0; op = 2'b00;
        check("busy_after_start", busy, 1);
        check("done_one_cycle", done, 0);
        k = 0;
        while (!done && k < 100) begin
            if (k == WIDTH) begin
                check("busy_in_wb", busy, 1);
                check("hi_stable", hi, prev_hi);
                check("lo_stable", lo, prev_lo);
            end
            tick();
            k++;
        end
        check("latency", k, LAT);
        check("done_seen", done, 1);
        check("busy_in_done", busy, 0);
        check("hi", hi, eh);
        check("lo", lo, el);
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        int k;
        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[2]  = '{2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{2'b10, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 32'h0000_000F};
        vecs[8]  = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{2'b10, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
        vecs[10] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2345_6781};

        // Reset held for two cycles.
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);

        // No-op encodings leave the unit idle; hilo_rd in idle never stalls.
        start = 1'b1; op = 2'b00; rs = 32'd5; rt = 32'd5;
        tick();
        check("noop00_busy", busy, 0);
        op = 2'b11;
        tick();
        start = 1'b0; op = 2'b00;
        check("noop11_busy", busy, 0);
        hilo_rd = 1'b1;
        #1;
        check("idle_stall", stall, 0);
        hilo_rd = 1'b0;
        tick();

        // Table vectors issued back to back: each start lands in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Stall behaviour and an ignored start during MUL.
        start = 1'b1; op = 2'b01; rs = 32'h0000_1234; rt = 32'h0000_0100;
        hilo_rd = 1'b1;
        #1;
        check("stall_same_cycle_start", stall, 0);
        tick();
        start = 1'b0; op = 2'b00; hilo_rd = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            if (k == 5) begin
                hilo_rd = 1'b1;
                #1;
                check("stall_mul", stall, 1);
            end
            if (k == 10) begin
                start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd4;
            end
            if (k == 11) begin
                start = 1'b0; op = 2'b00;
                check("stall_after_ignored", stall, 1);
            end
            if (k == WIDTH) check("stall_wb", stall, 1);
            tick();
            k++;
        end
        check("stall_latency", k, LAT);
        check("stall_done_cycle", stall, 0);
        check("ignore_hi", hi, 32'h0000_0000);
        check("ignore_lo", lo, 32'h0012_3400);
        hilo_rd = 1'b0;
        prev_hi = 32'h0000_0000;
        prev_lo = 32'h0012_3400;
        tick();
        check("ignored_not_relatched", busy, 0);

        // Asynchronous reset during MUL aborts the op and clears HI/LO at once.
        start = 1'b1; op = 2'b10; rs = 32'd5; rt = 32'd5;
        tick();
        start = 1'b0; op = 2'b00;
        hilo_rd = 1'b1;
        for (int j = 0; j < 10; j++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_stall", stall, 0);
        hilo_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        prev_hi = '0;
        prev_lo = '0;
        run_op(2'b10, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Sequential unsigned multiply/accumulate unit in the EX stage, directly downstream of the single-cycle control decoder.
- Consumes the decoded MULTU (R-format, funct 25) and MADDU (opcode 28) operations and owns the architectural HI/LO registers.
- Exposes HI/LO to the EX-stage MFHI/MFLO path.
- Generates a stall request so the hazard logic freezes IF/ID/EX while a HI/LO consumer waits on an in-flight multiply.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX-stage pulse: a multiply op is issued this cycle
- op  input  2  01 = MULTU, 10 = MADDU; 00 and 11 = no operation
- rs_val  input  WIDTH  multiplicand (forwarded rs value)
- rt_val  input  WIDTH  multiplier (forwarded rt value)
- hilo_rd  input  1  EX-stage instruction reads HI or LO (MFHI/MFLO)
- hi  output  WIDTH  architectural HI register
- lo  output  WIDTH  architectural LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO were updated on the previous edge
- stall  output  1  pipeline stall request

Behaviour:
- Reset (asynchronous, rst_n low):
  - hi = 0, lo = 0, busy = 0, done = 0, stall = 0.
  - State = IDLE; counter and internal accumulators are cleared.
  - Reset asserted mid-operation aborts the operation with no HI/LO update.
- States:
  - IDLE -> MUL: on start & (op == 01 or op == 10); rs_val, rt_val and op are latched at this edge.
  - MUL: one radix-2 iteration per cycle, WIDTH cycles total, counter 0..WIDTH-1.
  - MUL -> WB: after iteration WIDTH-1.
  - WB: HI/LO are written at the edge leaving WB.
    - MULTU: {hi,lo} = rs*rt, full 2*WIDTH-bit unsigned product.
    - MADDU: {hi,lo} = {hi,lo} + rs*rt modulo 2^(2*WIDTH); the carry out of bit 2*WIDTH-1 is discarded.
  - WB -> IDLE unconditionally.
- Latency:
  - start sampled at edge E; HI/LO update at edge E+WIDTH+1 (E+33 for WIDTH = 32).
  - done is high during the cycle after that update, for exactly one cycle.
- busy: high from the edge after an accepted start through the WB cycle inclusive; low in IDLE.
- stall: combinational, equals hilo_rd & busy.
  - It is never asserted for a hilo_rd issued in the same cycle as start, because busy is still low and the reader sees the old HI/LO.
  - Control orders instructions so this case does not arise.
- start while busy: ignored, with no re-latch and no error output. The hazard unit guarantees the pipeline does not issue one, because stall holds EX.
- start with op == 00 or 11: ignored; the unit stays in IDLE.
- Back-to-back operations: start is accepted in the cycle done is high, since the state is already IDLE. A MADDU accepted then accumulates onto the freshly written HI/LO.
- hi and lo are stable during MUL and WB and change only at the WB edge.
- All arithmetic is unsigned; no overflow or exception is signalled.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, then release -> hi = 0, lo = 0, busy = 0, done = 0, stall = 0. Assert rst_n = 0 asynchronously between edges during MUL -> outputs go to 0 immediately.
- MULTU worst case: rs = 0xFFFFFFFF, rt = 0xFFFFFFFF, start at edge E -> busy high at E+1 through E+33; hi = 0xFFFFFFFE, lo = 0x00000001 after E+33; done high for exactly one cycle after E+33.
- MADDU carry: preload via MULTU 0xFFFFFFFF*0x1 (gives hi = 0, lo = 0xFFFFFFFF), then MADDU 1*1 -> hi = 0x00000001, lo = 0x00000000.
- MADDU wrap: with hi = 0xFFFFFFFF, lo = 0xFFFFFFFF (preloaded via a MADDU sequence), MADDU 1*1 -> hi = 0, lo = 0, no other flag.
- Stall and ignore:
  - hilo_rd = 1 at cycle 5 of MUL -> stall = 1 until WB ends, stall = 0 in the done cycle.
  - A start with rs = 3, rt = 4 at cycle 10 of MUL is ignored; the final result matches the original operands.
- Back-to-back and no-op: start MULTU 0x0*0x12345678 -> hi = lo = 0. Issue start MADDU 7*6 in the done cycle -> lo = 42 after 33 more edges. start with op = 00 -> busy stays 0.
